// File: rtl/fu_logic_pipe_pkg.sv
// Shared types, opcode macros and flag indices for the logic/shift functional unit.
// Build option FU_LOGIC_BITCNT_EN enables the CLZ/POPCNT opcodes in fu_logic_core.
`ifndef FU_LOGIC_PIPE_PKG_DEFS
`define FU_LOGIC_PIPE_PKG_DEFS
`define AND_OP    4'd0
`define XOR_OP    4'd1
`define OR_OP     4'd2
`define NEG_OP    4'd3
`define LSLS_OP   4'd4
`define LSRS_OP   4'd5
`define ASRS_OP   4'd6
`define RORS_OP   4'd7
`define CLZ_OP    4'd8
`define POPCNT_OP 4'd9
`endif

package Purple_Jade_pkg;
  localparam int WIDTH_OP  = 4;
  localparam int NUM_FLAGS = 4;
  localparam int FLAG_C    = 3;
  localparam int FLAG_N    = 2;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_V    = 0;

  // Stage payload is sized for the widest legal configuration; unused upper bits stay 0.
  localparam int MAX_WIDTH = 64;
  localparam int MAX_TAG_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [MAX_WIDTH-1:0] result;
    logic [NUM_FLAGS-1:0] flags;
    logic [MAX_TAG_W-1:0] rob_dest;
    logic [MAX_TAG_W-1:0] reg_dest;
    logic                 illegal;
  } fu_logic_stage_t;
endpackage

// File: rtl/fu_logic_pipe_if.sv
// Issue/writeback bundle of the logic/shift unit; master = issue+CDB side, slave = unit.
interface fu_logic_pipe_if
  import Purple_Jade_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ROB_W  = 5,
  parameter int PREG_W = 6
);
  logic                 in_v_i;
  logic                 in_ready_o;
  logic [WIDTH_OP-1:0]  opcode_i;
  logic [WIDTH-1:0]     operand1_i;
  logic [WIDTH-1:0]     operand2_i;
  logic [ROB_W-1:0]     rob_dest_i;
  logic [PREG_W-1:0]    reg_dest_i;
  logic                 out_v_o;
  logic                 out_ready_i;
  logic [WIDTH-1:0]     result_o;
  logic [NUM_FLAGS-1:0] flags_o;
  logic [ROB_W-1:0]     rob_dest_o;
  logic [PREG_W-1:0]    reg_dest_o;
  logic                 illegal_o;

  modport slave (
    input  in_v_i, opcode_i, operand1_i, operand2_i, rob_dest_i, reg_dest_i, out_ready_i,
    output in_ready_o, out_v_o, result_o, flags_o, rob_dest_o, reg_dest_o, illegal_o
  );

  modport master (
    output in_v_i, opcode_i, operand1_i, operand2_i, rob_dest_i, reg_dest_i, out_ready_i,
    input  in_ready_o, out_v_o, result_o, flags_o, rob_dest_o, reg_dest_o, illegal_o
  );
endinterface

// File: rtl/fu_logic_pipe_core.sv
// Combinational op/flag compute for the logic/shift unit.
// FU_LOGIC_BITCNT_EN adds CLZ/POPCNT; otherwise those opcodes decode as illegal.
module fu_logic_core
  import Purple_Jade_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH_OP-1:0]  opcode,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  output logic [WIDTH-1:0]     result,
  output logic [NUM_FLAGS-1:0] flags,
  output logic                 illegal
);
  localparam int SHW  = $clog2(WIDTH) + 1;
  localparam int ROTW = $clog2(WIDTH);

  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] lsl_w, lsr_w, asr_w, ror_w;
  logic               carry, cnt_op;

  assign sh = op2[SHW-1:0];

  // Double-width shifts: the bit just past the result window is the carry-out,
  // which gives the sh==WIDTH and sh>WIDTH carry cases without special-casing.
  assign lsl_w = {{WIDTH{1'b0}}, op1} << sh;
  assign lsr_w = {op1, {WIDTH{1'b0}}} >> sh;
  assign asr_w = $signed({op1, {WIDTH{1'b0}}}) >>> sh;
  assign ror_w = {op1, op1} >> sh[ROTW-1:0];

  logic unused_core_bits;
  assign unused_core_bits = ^{lsl_w, lsr_w, asr_w, ror_w, op2};

`ifdef FU_LOGIC_BITCNT_EN
  logic [WIDTH-1:0] clz, popcnt;
  always_comb begin
    clz    = WIDTH'(WIDTH);
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (op1[i]) clz = WIDTH'(WIDTH - 1 - i);
      popcnt = popcnt + WIDTH'(op1[i]);
    end
  end
`endif

  always_comb begin
    result  = '0;
    carry   = 1'b0;
    cnt_op  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      `AND_OP:  result = op1 & op2;
      `XOR_OP:  result = op1 ^ op2;
      `OR_OP:   result = op1 | op2;
      `NEG_OP:  result = ~op1;
      `LSLS_OP: begin result = lsl_w[WIDTH-1:0];         carry = lsl_w[WIDTH];   end
      `LSRS_OP: begin result = lsr_w[2*WIDTH-1:WIDTH];   carry = lsr_w[WIDTH-1]; end
      `ASRS_OP: begin result = asr_w[2*WIDTH-1:WIDTH];   carry = asr_w[WIDTH-1]; end
      `RORS_OP: begin
        result = ror_w[WIDTH-1:0];
        carry  = (sh != '0) & ror_w[WIDTH-1];
      end
`ifdef FU_LOGIC_BITCNT_EN
      `CLZ_OP:    begin result = clz;    cnt_op = 1'b1; end
      `POPCNT_OP: begin result = popcnt; cnt_op = 1'b1; end
`endif
      default:  illegal = 1'b1;
    endcase
  end

  always_comb begin
    flags = '0;
    if (!illegal) begin
      flags[FLAG_Z] = (result == '0);
      if (cnt_op) begin
        flags[FLAG_C] = (op1 == '0);
      end else begin
        flags[FLAG_C] = carry;
        flags[FLAG_N] = result[WIDTH-1];
      end
    end
  end
endmodule

// File: rtl/fu_logic_pipe.sv
// Elastic STAGES-deep pipeline around fu_logic_core with valid/ready toward the CDB and flush.
// Optional CLZ/POPCNT ops are selected by FU_LOGIC_BITCNT_EN inside fu_logic_core.
module fu_logic_pipe
  import Purple_Jade_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int STAGES       = 2,
  parameter int ROB_ENTRY    = 32,
  parameter int NUM_PHYS_REG = 64,
  parameter int ROB_W        = $clog2(ROB_ENTRY),
  parameter int PREG_W       = $clog2(NUM_PHYS_REG)
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            flush_i,
  fu_logic_pipe_if.slave  bus
);
  logic [WIDTH-1:0]     core_res;
  logic [NUM_FLAGS-1:0] core_flags;
  logic                 core_ill;

  fu_logic_core #(.WIDTH(WIDTH)) u_core (
    .opcode  (bus.opcode_i),
    .op1     (bus.operand1_i),
    .op2     (bus.operand2_i),
    .result  (core_res),
    .flags   (core_flags),
    .illegal (core_ill)
  );

  fu_logic_stage_t   st_q   [STAGES];
  fu_logic_stage_t   stg_in [STAGES];
  logic [STAGES-1:0] vld, rdy;
  logic              accept;

  always_comb
    for (int k = 0; k < STAGES; k++) vld[k] = st_q[k].valid;

  // Stage k may load iff some stage at or downstream of k is empty, or the tail drains.
  always_comb
    for (int k = 0; k < STAGES; k++) begin
      rdy[k] = bus.out_ready_i;
      for (int j = k; j < STAGES; j++)
        if (!vld[j]) rdy[k] = 1'b1;
    end

  assign bus.in_ready_o = rdy[0] | flush_i;
  assign accept         = bus.in_v_i & rdy[0] & ~flush_i;

  always_comb begin
    stg_in[0]                       = '0;
    stg_in[0].valid                 = accept;
    stg_in[0].result[WIDTH-1:0]     = core_res;
    stg_in[0].flags                 = core_flags;
    stg_in[0].rob_dest[ROB_W-1:0]   = bus.rob_dest_i;
    stg_in[0].reg_dest[PREG_W-1:0]  = bus.reg_dest_i;
    stg_in[0].illegal               = core_ill;
    for (int k = 1; k < STAGES; k++) stg_in[k] = st_q[k-1];
  end

  // Payload only moves with a valid op so a bubble never disturbs held outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else if (flush_i) begin
      for (int k = 0; k < STAGES; k++) st_q[k].valid <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (rdy[k]) begin
          if (stg_in[k].valid) st_q[k]       <= stg_in[k];
          else                 st_q[k].valid <= 1'b0;
        end
    end
  end

  assign bus.out_v_o    = st_q[STAGES-1].valid;
  assign bus.result_o   = st_q[STAGES-1].result[WIDTH-1:0];
  assign bus.flags_o    = st_q[STAGES-1].flags;
  assign bus.rob_dest_o = st_q[STAGES-1].rob_dest[ROB_W-1:0];
  assign bus.reg_dest_o = st_q[STAGES-1].reg_dest[PREG_W-1:0];
  assign bus.illegal_o  = st_q[STAGES-1].illegal;

  logic unused_tail;
  assign unused_tail = ^st_q[STAGES-1];
endmodule

// File: tb/tb_fu_logic_pipe.sv
// Directed bench for fu_logic_pipe at WIDTH=16, STAGES=2.
module tb_fu_logic_pipe;
  import Purple_Jade_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  fu_logic_pipe_if #(.WIDTH(16), .ROB_W(5), .PREG_W(6)) bus ();

  fu_logic_pipe #(.WIDTH(16), .STAGES(2), .ROB_ENTRY(32), .NUM_PHYS_REG(64)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .flush_i   (flush),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic        r_v, r_ill;
  logic [15:0] r_res;
  logic [3:0]  r_flg;
  logic [4:0]  r_rob;
  logic [5:0]  r_reg;
  int          r_lat;
  logic [15:0] q_res [$];
  logic [4:0]  q_rob [$];
  int          wb_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] rob, input logic [5:0] rg);
    bus.in_v_i     = v;
    bus.opcode_i   = op;
    bus.operand1_i = a;
    bus.operand2_i = b;
    bus.rob_dest_i = rob;
    bus.reg_dest_i = rg;
  endtask

  // Issue one op into an empty pipe with out_ready=1 and capture its writeback.
  task automatic exec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [4:0] rob, input logic [5:0] rg);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    drive(1'b1, op, a, b, rob, rg);
    @(negedge clk);
    bus.in_v_i = 1'b0;
    #1;
    r_lat = 1;
    while (!bus.out_v_o && r_lat < 10) begin
      @(negedge clk); #1;
      r_lat++;
    end
    r_v   = bus.out_v_o;
    r_res = bus.result_o;
    r_flg = bus.flags_o;
    r_ill = bus.illegal_o;
    r_rob = bus.rob_dest_o;
    r_reg = bus.reg_dest_o;
  endtask

  task automatic exec_chk(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef);
    exec(op, a, b, 5'd7, 6'd9);
    chk({tag, "_v"}, 32'(r_v), 32'd1);
    chk({tag, "_res"}, 32'(r_res), 32'(er));
    chk({tag, "_flg"}, 32'(r_flg), 32'(ef));
  endtask

  initial begin
    bus.out_ready_i = 1'b0;
    drive(1'b0, 4'd0, 16'h0, 16'h0, 5'd0, 6'd0);

    // Reset state
    #12;
    chk("rst_out_v", 32'(bus.out_v_o), 32'd0);
    chk("rst_result", 32'(bus.result_o), 32'd0);
    chk("rst_flags", 32'(bus.flags_o), 32'd0);
    chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);

    // 1. AND with latency and tags
    exec(`AND_OP, 16'hF0F0, 16'hFF00, 5'd21, 6'd42);
    chk("and_v", 32'(r_v), 32'd1);
    chk("and_lat", 32'(r_lat), 32'd2);
    chk("and_res", 32'(r_res), 32'hF000);
    chk("and_flg", 32'(r_flg), 32'h4);
    chk("and_rob", 32'(r_rob), 32'd21);
    chk("and_reg", 32'(r_reg), 32'd42);
    @(negedge clk); #1;
    chk("and_once", 32'(bus.out_v_o), 32'd0);

    // 2. Logic and shift boundary vectors; flags {C,N,Z,V}
    exec_chk("xor_z",   `XOR_OP,  16'hFFFF, 16'hFFFF, 16'h0000, 4'h2);
    exec_chk("or",      `OR_OP,   16'h0F00, 16'h00F0, 16'h0FF0, 4'h0);
    exec_chk("neg",     `NEG_OP,  16'h0000, 16'h1234, 16'hFFFF, 4'h4);
    exec_chk("lsl1",    `LSLS_OP, 16'h8001, 16'd1,    16'h0002, 4'h8);
    exec_chk("lsl16",   `LSLS_OP, 16'h8001, 16'd16,   16'h0000, 4'hA);
    exec_chk("lsl17",   `LSLS_OP, 16'h8001, 16'd17,   16'h0000, 4'h2);
    exec_chk("lsl0hi",  `LSLS_OP, 16'h1234, 16'h0020, 16'h1234, 4'h0);
    exec_chk("lsr1",    `LSRS_OP, 16'h8001, 16'd1,    16'h4000, 4'h8);
    exec_chk("lsr16",   `LSRS_OP, 16'h8001, 16'd16,   16'h0000, 4'hA);
    exec_chk("asr20",   `ASRS_OP, 16'h8000, 16'd20,   16'hFFFF, 4'hC);
    exec_chk("asr4",    `ASRS_OP, 16'h8010, 16'd4,    16'hF801, 4'h4);
    exec_chk("ror1",    `RORS_OP, 16'h0001, 16'd1,    16'h8000, 4'hC);
    exec_chk("ror17",   `RORS_OP, 16'h0001, 16'd17,   16'h8000, 4'hC);

    // 6. Illegal and optional count ops
    exec(4'hF, 16'h1234, 16'h5678, 5'd3, 6'd4);
    chk("ill_v", 32'(r_v), 32'd1);
    chk("ill_res", 32'(r_res), 32'd0);
    chk("ill_flg", 32'(r_flg), 32'd0);
    chk("ill_bit", 32'(r_ill), 32'd1);
    @(negedge clk); #1;
    chk("ill_once", 32'(bus.out_v_o), 32'd0);
`ifdef FU_LOGIC_BITCNT_EN
    exec_chk("clz",    `CLZ_OP,    16'h00F0, 16'h0, 16'd8,  4'h0);
    exec_chk("clz0",   `CLZ_OP,    16'h0000, 16'h0, 16'd16, 4'h8);
    exec_chk("popcnt", `POPCNT_OP, 16'hFFFF, 16'h0, 16'd16, 4'h0);
`else
    exec(`CLZ_OP, 16'h00F0, 16'h0, 5'd1, 6'd1);
    chk("clz_ill", 32'(r_ill), 32'd1);
    chk("clz_res", 32'(r_res), 32'd0);
    exec(`POPCNT_OP, 16'hFFFF, 16'h0, 5'd1, 6'd1);
    chk("pop_ill", 32'(r_ill), 32'd1);
    chk("pop_res", 32'(r_res), 32'd0);
`endif

    // 3. Backpressure: fill with out_ready=0, hold, release and drain in order
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    drive(1'b1, `AND_OP, 16'h00FF, 16'h0F0F, 5'd1, 6'd1);
    #1; chk("stall_rdy_a", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk);
    drive(1'b1, `OR_OP, 16'h1000, 16'h0001, 5'd2, 6'd2);
    #1; chk("stall_rdy_b", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk);
    drive(1'b1, `XOR_OP, 16'hAAAA, 16'h5555, 5'd3, 6'd3);
    #1;
    chk("stall_full", 32'(bus.in_ready_o), 32'd0);
    chk("stall_v", 32'(bus.out_v_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("stall_hold_res", 32'(bus.result_o), 32'h000F);
      chk("stall_hold_rob", 32'(bus.rob_dest_o), 32'd1);
      chk("stall_hold_rdy", 32'(bus.in_ready_o), 32'd0);
    end
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    #1;
    chk("stall_release_rdy", 32'(bus.in_ready_o), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        bus.in_v_i = 1'b0;
        #1;
      end
      if (bus.out_v_o) begin
        q_res.push_back(bus.result_o);
        q_rob.push_back(bus.rob_dest_o);
      end
    end
    chk("drain_cnt", 32'(q_res.size()), 32'd3);
    if (q_res.size() == 3) begin
      chk("drain_0", 32'(q_res[0]), 32'h000F);
      chk("drain_1", 32'(q_res[1]), 32'h1001);
      chk("drain_2", 32'(q_res[2]), 32'hFFFF);
      chk("drain_rob2", 32'(q_rob[2]), 32'd3);
    end

    // 4. Flush with a same-cycle op
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    drive(1'b1, `OR_OP, 16'h0001, 16'h0002, 5'd4, 6'd4);
    @(negedge clk);
    drive(1'b1, `OR_OP, 16'h0010, 16'h0020, 5'd5, 6'd5);
    @(negedge clk);
    drive(1'b1, `OR_OP, 16'h0100, 16'h0200, 5'd6, 6'd6);
    flush = 1'b1;
    #1; chk("flush_rdy", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    bus.in_v_i = 1'b0;
    bus.out_ready_i = 1'b1;
    wb_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1; if (bus.out_v_o) wb_cnt++;
      @(negedge clk);
    end
    chk("flush_no_wb", 32'(wb_cnt), 32'd0);
    exec_chk("post_flush", `XOR_OP, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'h0);

    // 5. Asynchronous reset mid-stream
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    drive(1'b1, `AND_OP, 16'hFFFF, 16'h1111, 5'd8, 6'd8);
    @(negedge clk);
    drive(1'b1, `AND_OP, 16'hFFFF, 16'h2222, 5'd9, 6'd9);
    @(negedge clk);
    bus.in_v_i = 1'b0;
    #1; chk("pre_rst_v", 32'(bus.out_v_o), 32'd1);
    #1; rst_n = 1'b0;
    #1;
    chk("async_rst_v", 32'(bus.out_v_o), 32'd0);
    chk("async_rst_res", 32'(bus.result_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1; chk("post_rst_rdy", 32'(bus.in_ready_o), 32'd1);
    wb_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (bus.out_v_o) wb_cnt++;
    end
    chk("post_rst_no_wb", 32'(wb_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
